fft_out_reorder: RTL

//  Output-side stage placed directly downstream of topfft. It captures the 4 parallel,

---
 rtl/fft_pkg.sv | 46 ++++
 rtl/fft_out_reorder_if.sv | 42 ++++
 rtl/reorder_bank.sv | 37 +++
 rtl/fft_out_reorder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : fft_pkg                                                       |
// | Description: Shared FFT constants, word/beat types, bin bit-reversal and   |
// |              state encodings for the FFT output reorder stage.             |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package fft_pkg;

    localparam int DW    = 30;          // complex word {re[14:0], im[14:0]}
    localparam int N     = 32;          // FFT points per frame
    localparam int P     = 4;           // lanes per beat
    localparam int LOG2N = 5;
    localparam int LOG2P = 2;
    localparam int BEATS = N / P;       // beats per frame
    localparam int BW    = LOG2N - LOG2P; // beat counter width

    typedef logic [DW-1:0]  word_t;
    typedef word_t [P-1:0]  beat_t;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_t;

    // Reverse the LOG2N-bit bin index (radix-2 output ordering).
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] res;
        for (int i = 0; i < LOG2N; i++) begin
            res[i] = idx[LOG2N-1-i];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_out_reorder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : fft_out_reorder_if                                            |
// | Description: Input lane bus from topfft and the natural-order output bus,  |
// |              plus the frame error pulses. master = source/sink side,       |
// |              slave = the reorder stage.                                    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface fft_out_reorder_if;
    import fft_pkg::*;

    logic  in_valid;
    logic  in_start;
    word_t in_lane0;
    word_t in_lane1;
    word_t in_lane2;
    word_t in_lane3;
    logic  out_ready;
    logic  out_valid;
    logic  out_start;
    logic  out_last;
    word_t out_lane0;
    word_t out_lane1;
    word_t out_lane2;
    word_t out_lane3;
    logic  ovf;
    logic  frm_err;

    modport master (
        output in_valid, in_start, in_lane0, in_lane1, in_lane2, in_lane3, out_ready,
        input  out_valid, out_start, out_last, out_lane0, out_lane1, out_lane2, out_lane3,
        input  ovf, frm_err
    );

    modport slave (
        input  in_valid, in_start, in_lane0, in_lane1, in_lane2, in_lane3, out_ready,
        output out_valid, out_start, out_last, out_lane0, out_lane1, out_lane2, out_lane3,
        output ovf, frm_err
    );

endinterface
`default_nettype wire

// File: rtl/reorder_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : reorder_bank                                                  |
// | Description: N x DW register file. Writes one beat of P bins at their      |
// |              bit-reversed addresses, reads P consecutive natural bins.     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module reorder_bank
    import fft_pkg::*;
(
    input  logic          clk,
    input  logic          i_we,
    input  logic [BW-1:0] i_wbeat,
    input  beat_t         i_wdata,
    input  logic [BW-1:0] i_rbeat,
    output beat_t         o_rdata
);

    word_t r_mem [N];

    // Scatter the incoming beat: lane l of beat k is bin bitrev(P*k + l).
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int l = 0; l < P; l++) begin
                r_mem[bitrev({i_wbeat, LOG2P'(l)})] <= i_wdata[l];
            end
        end
    end

    generate
        for (genvar l = 0; l < P; l++) begin : g_rd
            assign o_rdata[l] = r_mem[{i_rbeat, LOG2P'(l)}];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fft_out_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : fft_out_reorder                                               |
// | Description: Captures bit-reversed FFT lanes into a ping-pong register     |
// |              buffer and drains each frame in natural bin order, P bins per |
// |              beat, under valid/ready. Lost frames raise ovf / frm_err.     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module fft_out_reorder
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fft_out_reorder_if.slave bus
);

    localparam logic [BW-1:0] c_last_beat = BW'(BEATS - 1);

    // write side
    wr_state_t     r_wr_state, w_wr_state_nxt;
    logic [BW-1:0] r_wcnt, w_wcnt_nxt;
    logic          r_wr_bank, w_wr_bank_nxt;
    logic          w_we;
    logic [BW-1:0] w_wbeat;
    logic          w_set_full;
    logic          w_ovf_nxt, w_frm_err_nxt;

    // read side
    rd_state_t     r_rd_state, w_rd_state_nxt;
    logic [BW-1:0] r_rcnt, w_rcnt_nxt;
    logic          r_rd_bank, w_rd_bank_nxt;
    logic          w_release;
    logic          w_load;
    logic          w_ld_bank;
    logic [BW-1:0] w_ld_beat;
    logic          w_out_valid_nxt;

    // bank flags
    bank_state_t   r_bank_state [2];
    bank_state_t   w_bank_eff   [2];
    bank_state_t   w_bank_nxt   [2];

    // data path
    beat_t         w_in_beat;
    beat_t         w_bank_rdata [2];
    beat_t         w_ld_data;

    // output register stage
    logic          r_out_valid, r_out_start, r_out_last;
    beat_t         r_out_lane;
    logic          r_ovf, r_frm_err;

    assign w_in_beat = {bus.in_lane3, bus.in_lane2, bus.in_lane1, bus.in_lane0};

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            reorder_bank u_bank (
                .clk     (clk),
                .i_we    (w_we && (r_wr_bank == 1'(b))),
                .i_wbeat (w_wbeat),
                .i_wdata (w_in_beat),
                .i_rbeat (w_ld_beat),
                .o_rdata (w_bank_rdata[b])
            );
        end
    endgenerate

    assign w_ld_data = w_ld_bank ? w_bank_rdata[1] : w_bank_rdata[0];

    // Bank flags as the write side sees them: a bank released this cycle is already free.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_bank_eff[b] = r_bank_state[b];
            if (w_release && (r_rd_bank == 1'(b))) begin
                w_bank_eff[b] = BANK_EMPTY;
            end
        end
    end

    // Next bank flags: apply the completed-frame mark on top of the release.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_bank_nxt[b] = w_bank_eff[b];
            if (w_set_full && (r_wr_bank == 1'(b))) begin
                w_bank_nxt[b] = BANK_FULL;
            end
        end
    end

    // Write FSM next-state: frame acceptance, fill counting, restart and overflow.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wcnt_nxt     = r_wcnt;
        w_wr_bank_nxt  = r_wr_bank;
        w_we           = 1'b0;
        w_wbeat        = r_wcnt;
        w_set_full     = 1'b0;
        w_ovf_nxt      = 1'b0;
        w_frm_err_nxt  = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (bus.in_valid && bus.in_start) begin
                    if (w_bank_eff[r_wr_bank] == BANK_EMPTY) begin
                        w_we           = 1'b1;
                        w_wbeat        = '0;
                        w_wcnt_nxt     = BW'(1);
                        w_wr_state_nxt = W_FILL;
                    end else begin
                        w_ovf_nxt = 1'b1;
                    end
                end
            end
            W_FILL: begin
                if (bus.in_valid) begin
                    w_we = 1'b1;
                    if (bus.in_start) begin
                        // restart in the same bank; the partial frame is overwritten
                        w_frm_err_nxt = 1'b1;
                        w_wbeat       = '0;
                        w_wcnt_nxt    = BW'(1);
                    end else if (r_wcnt == c_last_beat) begin
                        w_set_full     = 1'b1;
                        w_wr_bank_nxt  = ~r_wr_bank;
                        w_wcnt_nxt     = '0;
                        w_wr_state_nxt = W_IDLE;
                    end else begin
                        w_wcnt_nxt = r_wcnt + BW'(1);
                    end
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    // Read FSM next-state: picks the beat to load into the output register.
    always_comb begin
        w_rd_state_nxt  = r_rd_state;
        w_rd_bank_nxt   = r_rd_bank;
        w_rcnt_nxt      = r_rcnt;
        w_release       = 1'b0;
        w_load          = 1'b0;
        w_ld_bank       = r_rd_bank;
        w_ld_beat       = r_rcnt;
        w_out_valid_nxt = r_out_valid;
        case (r_rd_state)
            R_IDLE: begin
                if (r_bank_state[r_rd_bank] == BANK_FULL) begin
                    w_rd_state_nxt  = R_DRAIN;
                    w_rcnt_nxt      = '0;
                    w_load          = 1'b1;
                    w_ld_beat       = '0;
                    w_out_valid_nxt = 1'b1;
                end
            end
            R_DRAIN: begin
                if (bus.out_ready) begin
                    if (r_rcnt == c_last_beat) begin
                        w_release     = 1'b1;
                        w_rd_bank_nxt = ~r_rd_bank;
                        w_rcnt_nxt    = '0;
                        if (r_bank_state[~r_rd_bank] == BANK_FULL) begin
                            // chain straight into the next frame without a bubble
                            w_load    = 1'b1;
                            w_ld_bank = ~r_rd_bank;
                            w_ld_beat = '0;
                        end else begin
                            w_rd_state_nxt  = R_IDLE;
                            w_out_valid_nxt = 1'b0;
                        end
                    end else begin
                        w_rcnt_nxt = r_rcnt + BW'(1);
                        w_load     = 1'b1;
                        w_ld_beat  = r_rcnt + BW'(1);
                    end
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    // State, counter and bank-flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_state <= W_IDLE;
            r_wcnt     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_state <= R_IDLE;
            r_rcnt     <= '0;
            r_rd_bank  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                r_bank_state[b] <= BANK_EMPTY;
            end
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_wr_bank  <= w_wr_bank_nxt;
            r_rd_state <= w_rd_state_nxt;
            r_rcnt     <= w_rcnt_nxt;
            r_rd_bank  <= w_rd_bank_nxt;
            for (int b = 0; b < 2; b++) begin
                r_bank_state[b] <= w_bank_nxt[b];
            end
        end
    end

    // Output register stage: holds the current beat until it is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_start <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_lane  <= '0;
            r_ovf       <= 1'b0;
            r_frm_err   <= 1'b0;
        end else begin
            r_out_valid <= w_out_valid_nxt;
            if (w_load) begin
                r_out_lane  <= w_ld_data;
                r_out_start <= (w_ld_beat == '0);
                r_out_last  <= (w_ld_beat == c_last_beat);
            end else if (!w_out_valid_nxt) begin
                r_out_start <= 1'b0;
                r_out_last  <= 1'b0;
            end
            r_ovf     <= w_ovf_nxt;
            r_frm_err <= w_frm_err_nxt;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_start = r_out_start;
    assign bus.out_last  = r_out_last;
    assign bus.out_lane0 = r_out_lane[0];
    assign bus.out_lane1 = r_out_lane[1];
    assign bus.out_lane2 = r_out_lane[2];
    assign bus.out_lane3 = r_out_lane[3];
    assign bus.ovf       = r_ovf;
    assign bus.frm_err   = r_frm_err;

endmodule
`default_nettype wire
